full_adder_311: RTL and testbench

Single-bit full adder with registered outputs and the internal half-adder terms exposed for observation. It accepts operand bits a/b and carry-in c under a valid strobe and presents sum, carry-out and the three intermediate terms one clock later. It is the leaf cell of the team's adder/subtractor set and is intended for chaining into ripple structures and for gate-level teaching/debug, where the intermediate terms are probed.

---
 rtl/full_adder_311.sv | 47 ++++
 tb/tb_full_adder_311.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/full_adder_311.sv
// full_adder_311: single-bit full adder with registered sum/carry, exposed half-adder terms and an accept counter
module full_adder_311 (
    input  logic       clk_311,
    input  logic       rst_311,
    input  logic       v_311,
    input  logic       a_311,
    input  logic       b_311,
    input  logic       c_311,
    output logic       s_311,
    output logic       cy_311,
    output logic       x_311,
    output logic       y_311,
    output logic       z_311,
    output logic       vo_311,
    output logic [7:0] cnt_311
);
    logic x, y, z, s, cy;
    // Two cascaded half adders; their terms are kept so they can be probed downstream.
    always_comb begin
        x  = a_311 ^ b_311;
        y  = a_311 & b_311;
        z  = x & c_311;
        s  = x ^ c_311;
        cy = y | z;
    end
    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            s_311   <= 1'b0;
            cy_311  <= 1'b0;
            x_311   <= 1'b0;
            y_311   <= 1'b0;
            z_311   <= 1'b0;
            vo_311  <= 1'b0;
            cnt_311 <= 8'd0;
        end else begin
            vo_311 <= v_311;
            if (v_311) begin
                s_311   <= s;
                cy_311  <= cy;
                x_311   <= x;
                y_311   <= y;
                z_311   <= z;
                cnt_311 <= cnt_311 + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_full_adder_311.sv
// tb_full_adder_311: directed and random checks of full_adder_311 against hand-computed values
module tb_full_adder_311;
    logic       clk_311 = 1'b0;
    logic       rst_311 = 1'b1;
    logic       v_311 = 1'b0;
    logic       a_311 = 1'b0;
    logic       b_311 = 1'b0;
    logic       c_311 = 1'b0;
    logic       s_311, cy_311, x_311, y_311, z_311, vo_311;
    logic [7:0] cnt_311;
    int         errors = 0;
    int         checks = 0;

    full_adder_311 dut (
        .clk_311(clk_311), .rst_311(rst_311), .v_311(v_311),
        .a_311(a_311), .b_311(b_311), .c_311(c_311),
        .s_311(s_311), .cy_311(cy_311), .x_311(x_311), .y_311(y_311), .z_311(z_311),
        .vo_311(vo_311), .cnt_311(cnt_311)
    );

    always #5 clk_311 = ~clk_311;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_311);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {2'b00, s_311, cy_311, x_311, y_311, z_311, vo_311}, 8'd0);
        chk(tag, cnt_311, 8'd0);
    endtask

    task automatic do_reset();
        rst_311 = 1'b1;
        v_311 = 1'b0;
        step();
        step();
        rst_311 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s_tab, cy_tab, x_tab, y_tab, z_tab;
        logic [1:0] exp_sum;
        logic       exp_vo;
        logic [7:0] exp_cnt;
        s_tab  = 8'h96;
        cy_tab = 8'hE8;
        x_tab  = 8'h3C;
        y_tab  = 8'hC0;
        z_tab  = 8'h28;
        // reset with all inputs high
        rst_311 = 1'b1;
        v_311 = 1'b1; a_311 = 1'b1; b_311 = 1'b1; c_311 = 1'b1;
        #1;
        all_zero("rst_async");
        step();
        step();
        all_zero("rst_held");
        rst_311 = 1'b0;
        v_311 = 1'b0;
        step();
        all_zero("rst_release");
        // exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            {a_311, b_311, c_311} = 3'(i);
            v_311 = 1'b1;
            step();
            chk($sformatf("tt%0d_s", i), 8'(s_311), 8'(s_tab[i]));
            chk($sformatf("tt%0d_cy", i), 8'(cy_311), 8'(cy_tab[i]));
            chk($sformatf("tt%0d_x", i), 8'(x_311), 8'(x_tab[i]));
            chk($sformatf("tt%0d_y", i), 8'(y_311), 8'(y_tab[i]));
            chk($sformatf("tt%0d_z", i), 8'(z_311), 8'(z_tab[i]));
            chk($sformatf("tt%0d_vo", i), 8'(vo_311), 8'd1);
        end
        chk("tt_cnt", cnt_311, 8'd8);
        // hold
        {a_311, b_311, c_311} = 3'b111;
        v_311 = 1'b1;
        step();
        chk("hold_cap_vo", 8'(vo_311), 8'd1);
        v_311 = 1'b0;
        {a_311, b_311, c_311} = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_s", 8'(s_311), 8'd1);
            chk("hold_cy", 8'(cy_311), 8'd1);
            chk("hold_vo", 8'(vo_311), 8'd0);
            chk("hold_cnt", cnt_311, 8'd9);
        end
        // async reset mid-stream
        {a_311, b_311, c_311} = 3'b011;
        v_311 = 1'b1;
        step();
        chk("ar_pre_s", 8'(s_311), 8'd0);
        chk("ar_pre_cy", 8'(cy_311), 8'd1);
        chk("ar_pre_z", 8'(z_311), 8'd1);
        chk("ar_pre_vo", 8'(vo_311), 8'd1);
        #2 rst_311 = 1'b1;
        #1;
        all_zero("ar_mid");
        #1 rst_311 = 1'b0;
        v_311 = 1'b0;
        step();
        chk("ar_pending_vo", 8'(vo_311), 8'd0);
        {a_311, b_311, c_311} = 3'b100;
        v_311 = 1'b1;
        step();
        chk("ar_post_s", 8'(s_311), 8'd1);
        chk("ar_post_cy", 8'(cy_311), 8'd0);
        chk("ar_post_x", 8'(x_311), 8'd1);
        chk("ar_post_cnt", cnt_311, 8'd1);
        // counter wrap
        do_reset();
        v_311 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            {a_311, b_311, c_311} = 3'(i);
            step();
            if (i == 255) chk("wrap_255", cnt_311, 8'd255);
            if (i == 256) chk("wrap_0", cnt_311, 8'd0);
        end
        // random
        do_reset();
        exp_sum = 2'd0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 1000; i++) begin
            v_311 = 1'($urandom_range(0, 1));
            a_311 = 1'($urandom_range(0, 1));
            b_311 = 1'($urandom_range(0, 1));
            c_311 = 1'($urandom_range(0, 1));
            step();
            exp_vo = v_311;
            if (v_311) begin
                exp_sum = 2'(a_311) + 2'(b_311) + 2'(c_311);
                exp_cnt = exp_cnt + 8'd1;
            end
            chk("rnd_vo", 8'(vo_311), 8'(exp_vo));
            chk("rnd_sum", 8'({cy_311, s_311}), 8'(exp_sum));
            chk("rnd_cnt", cnt_311, exp_cnt);
            chk("rnd_yz", 8'(y_311 & z_311), 8'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
